// File: rtl/push_pkg.sv
// Shared types and constants for the push-button conditioning slice:
// per-button FSM states, board button indices and a small sizing helper.
package push_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } btn_state_e;

    localparam int BTN_ARRIBA = 0;
    localparam int BTN_ABAJO  = 1;
    localparam int BTN_IZQ    = 2;
    localparam int BTN_DER    = 3;
    localparam int BTN_CENTRO = 4;

    function automatic int unsigned push_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/push_conditioner_if.sv
// Button bundle between the raw board pins and the conditioned push_* consumers.
// The slave modport is the conditioner side.
interface push_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic             btn_any;

    modport master (output btn_raw, input btn_level, input btn_pulse, input btn_any);
    modport slave  (input btn_raw, output btn_level, output btn_pulse, output btn_any);
endinterface

// File: rtl/push_debounce_fsm.sv
// One button: 2-flop synchroniser, debounce FSM and, when PUSH_AUTOREPEAT_EN is
// defined, the auto-repeat counter with lockout hold.
module push_debounce_fsm
    import push_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic Reset,
    input  logic btn_raw,
    input  logic repeat_en,
    input  logic lockout,
    output logic level,
    output logic pulse,
    output logic pulse_nxt,
    output logic held
);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync;
    btn_state_e       state_q, state_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic             level_d;
    logic             press;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (Reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], btn_raw};
    end
    assign sync = sync_q[1];
    assign held = (state_q == HELD);

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        level_d = level;
        press   = 1'b0;
        unique case (state_q)
            IDLE: if (sync) begin
                state_d = PRESS_DEB;
                deb_d   = DEB_W'(1);
            end
            PRESS_DEB: begin
                if (!sync) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = HELD;
                    deb_d   = '0;
                    level_d = 1'b1;
                    press   = 1'b1;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            HELD: if (!sync) begin
                state_d = RELEASE_DEB;
                deb_d   = DEB_W'(1);
            end
            RELEASE_DEB: begin
                if (sync) begin
                    state_d = HELD;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = IDLE;
                    deb_d   = '0;
                    level_d = 1'b0;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PUSH_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(push_max(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    logic [REP_W-1:0] rep_q, rep_d, rep_last;
    logic             first_q, first_d;
    logic             rep_fire;

    assign rep_last = first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);

    // The counter only advances on cycles spent in HELD with the input still high,
    // so a bounce through RELEASE_DEB freezes the cadence rather than restarting it.
    always_comb begin
        rep_d    = rep_q;
        first_d  = first_q;
        rep_fire = 1'b0;
        if (press) begin
            rep_d   = '0;
            first_d = 1'b1;
        end else if (held && sync && repeat_en) begin
            if (lockout) begin
                rep_d = '0;
            end else if (rep_q == rep_last) begin
                rep_d    = '0;
                first_d  = 1'b0;
                rep_fire = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rep_q   <= '0;
            first_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end
    end

    assign pulse_nxt = press | rep_fire;
`else
    logic unused_cfg;
    assign unused_cfg = ^{repeat_en, lockout, REPEAT_DELAY, REPEAT_PERIOD};
    assign pulse_nxt  = press;
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            deb_q   <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            level   <= level_d;
            pulse   <= pulse_nxt;
        end
    end

endmodule

// File: rtl/push_conditioner.sv
// Conditions the five board push buttons into clean levels and press/repeat pulses.
// Define PUSH_AUTOREPEAT_EN to build auto-repeat and opposite-direction lockout.
module push_conditioner
    import push_pkg::*;
#(
    parameter int unsigned      N_BTN         = 5,
    parameter int unsigned      DEB_CYCLES    = 1000000,
    parameter int unsigned      REPEAT_DELAY  = 50000000,
    parameter int unsigned      REPEAT_PERIOD = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = 'b01111
) (
    input logic               clk,
    input logic               Reset,
    push_conditioner_if.slave bus
);
    logic [N_BTN-1:0] held;
    logic [N_BTN-1:0] lockout;
    logic [N_BTN-1:0] pulse_nxt;
    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] pulse_v;
    logic             any_q;

    // Opposite directions held together cancel each other's repeats.
    always_comb begin
        lockout             = '0;
        lockout[BTN_ARRIBA] = held[BTN_ARRIBA] & held[BTN_ABAJO];
        lockout[BTN_ABAJO]  = held[BTN_ARRIBA] & held[BTN_ABAJO];
        lockout[BTN_IZQ]    = held[BTN_IZQ] & held[BTN_DER];
        lockout[BTN_DER]    = held[BTN_IZQ] & held[BTN_DER];
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        push_debounce_fsm #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_fsm (
            .clk      (clk),
            .Reset    (Reset),
            .btn_raw  (bus.btn_raw[i]),
            .repeat_en(REPEAT_MASK[i]),
            .lockout  (lockout[i]),
            .level    (level_v[i]),
            .pulse    (pulse_v[i]),
            .pulse_nxt(pulse_nxt[i]),
            .held     (held[i])
        );
    end

    always_ff @(posedge clk) begin
        if (Reset) any_q <= 1'b0;
        else       any_q <= |pulse_nxt;
    end

    assign bus.btn_level = level_v;
    assign bus.btn_pulse = pulse_v;
    assign bus.btn_any   = any_q;

endmodule

// File: tb/tb_push_conditioner.sv
// Directed and randomized bench for push_conditioner against a run-length
// reference model of debounce, repeat cadence and lockout.
module tb_push_conditioner;
    localparam int N   = 5;
    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;
`ifdef PUSH_AUTOREPEAT_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    push_conditioner_if #(.N_BTN(N)) bus ();

    push_conditioner #(
        .N_BTN        (N),
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER),
        .REPEAT_MASK  (5'b01111)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] mask_v = 5'b01111;
    logic [N-1:0] d1, d2, m_level, m_last, m_pulse;
    int           m_run   [N];
    int           m_rep   [N];
    bit           m_first [N];
    int           pcnt    [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Level flips once DEB consecutive synchronised samples disagree with it;
    // repeats count cycles spent held-high since the press or last repeat.
    task automatic model_edge(input logic [N-1:0] raw, input logic rst);
        logic [N-1:0] sync, held_pre;
        int tgt;
        if (rst) begin
            d1 = '0; d2 = '0; m_level = '0; m_last = '0; m_pulse = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_rep[i] = 0; m_first[i] = 1'b0;
            end
            return;
        end
        sync     = d2;
        d2       = d1;
        d1       = raw;
        held_pre = m_level & m_last;
        m_pulse  = '0;
        for (int i = 0; i < N; i++) begin
            if (sync[i] != m_level[i]) m_run[i]++;
            else                       m_run[i] = 0;
            if (m_run[i] == DEB) begin
                m_level[i] = sync[i];
                m_run[i]   = 0;
                if (sync[i]) begin
                    m_pulse[i] = 1'b1;
                    m_rep[i]   = 0;
                    m_first[i] = 1'b1;
                end
            end else if (AR_EN && mask_v[i] && held_pre[i] && sync[i]) begin
                if (i < 4 && held_pre[i ^ 1]) begin
                    m_rep[i] = 0;
                end else begin
                    m_rep[i]++;
                    tgt = m_first[i] ? DLY : PER;
                    if (m_rep[i] == tgt) begin
                        m_pulse[i] = 1'b1;
                        m_rep[i]   = 0;
                        m_first[i] = 1'b0;
                    end
                end
            end
        end
        m_last = sync;
    endtask

    task automatic step(input logic [N-1:0] raw);
        bus.btn_raw = raw;
        @(posedge clk);
        model_edge(raw, Reset);
        #1;
        check("level", 32'(bus.btn_level), 32'(m_level));
        check("pulse", 32'(bus.btn_pulse), 32'(m_pulse));
        check("any", 32'(bus.btn_any), 32'(|m_pulse));
        for (int i = 0; i < N; i++) pcnt[i] += int'(bus.btn_pulse[i]);
    endtask

    task automatic steps(input logic [N-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) pcnt[i] = 0;
    endtask

    initial begin
        logic [N-1:0] cur;
        logic         pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

        bus.btn_raw = '0;
        Reset = 1'b1;
        clear_counts();
        steps('0, 3);
        check("reset_level", 32'(bus.btn_level), 32'(0));
        check("reset_pulse", 32'(bus.btn_pulse), 32'(0));
        check("reset_any", 32'(bus.btn_any), 32'(0));
        Reset = 1'b0;
        steps('0, 3);

        // Clean press on arriba: pulse on the 6th edge after the rise.
        clear_counts();
        steps(5'b00001, 5);
        check("press_early", 32'(bus.btn_pulse), 32'(0));
        step(5'b00001);
        check("press_pulse", 32'(bus.btn_pulse), 32'(5'b00001));
        check("press_any", 32'(bus.btn_any), 32'(1));
        check("press_level", 32'(bus.btn_level[0]), 32'(1));
        steps(5'b00001, 4);
        steps('0, 10);
        check("press_once", 32'(pcnt[0]), 32'(1));

        // Bounce on izquierda.
        clear_counts();
        for (int k = 0; k < 9; k++) step({2'b00, pat[k], 2'b00});
        steps(5'b00100, 6);
        steps('0, 10);
        check("bounce_once", 32'(pcnt[2]), 32'(1));

        // Long hold: derecha repeats, centro never does.
        clear_counts();
        steps(5'b11000, 60);
        steps('0, 10);
        check("hold_der", 32'(pcnt[3]), 32'(AR_EN ? 6 : 1));
        check("hold_centro", 32'(pcnt[4]), 32'(1));

        // Opposite pair lockout, then release of abajo.
        clear_counts();
        steps(5'b00011, 60);
        check("pair_arriba", 32'(pcnt[0]), 32'(1));
        check("pair_abajo", 32'(pcnt[1]), 32'(1));
        clear_counts();
        steps(5'b00001, 30);
        check("unlock_arriba", 32'(pcnt[0]), 32'(AR_EN ? 1 : 0));
        check("unlock_abajo", 32'(pcnt[1]), 32'(0));
        steps('0, 10);

        // Two-cycle release glitch during a hold.
        clear_counts();
        steps(5'b01000, 30);
        steps('0, 2);
        step(5'b01000);
        check("glitch_level", 32'(bus.btn_level[3]), 32'(1));
        steps(5'b01000, 29);
        steps('0, 10);
        check("glitch_cnt", 32'(pcnt[3]), 32'(AR_EN ? 6 : 1));

        // Reset while arriba is held in repeat.
        steps(5'b00001, 30);
        Reset = 1'b1;
        step(5'b00001);
        check("rst_mid_level", 32'(bus.btn_level), 32'(0));
        check("rst_mid_pulse", 32'(bus.btn_pulse), 32'(0));
        check("rst_mid_any", 32'(bus.btn_any), 32'(0));
        step(5'b00001);
        Reset = 1'b0;
        steps(5'b00001, 5);
        check("rst_repress_early", 32'(bus.btn_pulse), 32'(0));
        step(5'b00001);
        check("rst_repress", 32'(bus.btn_pulse), 32'(5'b00001));
        steps(5'b00001, 4);
        steps('0, 10);

        // Randomized: fast chatter, then slow holds with occasional resets.
        cur = '0;
        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) cur[i] = ~cur[i];
            step(cur);
        end
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 29) == 0) cur[i] = ~cur[i];
            Reset = ($urandom_range(0, 199) == 0);
            step(cur);
        end
        Reset = 1'b0;
        steps('0, 12);
        check("final_level", 32'(bus.btn_level), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
